// File: rtl/pwm_gen.sv
// Edge-aligned PWM with complementary dead-band outputs.
// Period, duty and dead time are double-buffered behind a valid/ready port.
module pwm_gen #(
    parameter int CNT_W = 16,
    parameter int DT_W  = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             tick_en,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    input  logic [DT_W-1:0]  cfg_dead,
    output logic             pwm_hi,
    output logic             pwm_lo,
    output logic             period_start,
    output logic [CNT_W-1:0] cnt_out
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [DT_W-1:0]  DT_ONE  = 1;

    typedef enum logic [2:0] {
        S_OFF,
        S_HI,
        S_DTL,
        S_LO,
        S_DTH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_q, duty_q, period_s, duty_s;
    logic [DT_W-1:0]  dead_q, dead_s, dt;
    logic             pending;
    logic             raw;
    logic             wrap;

    assign raw       = (cnt < duty_q);
    assign wrap      = tick_en && enable && (cnt == period_q);
    assign cfg_ready = ~pending;
    assign cnt_out   = cnt;

    // Shadow loads on handshake; active copies only at a safe point.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            period_q <= '0;
            duty_q   <= '0;
            dead_q   <= '0;
            period_s <= '0;
            duty_s   <= '0;
            dead_s   <= '0;
            pending  <= 1'b0;
        end else if (cfg_valid && !pending) begin
            period_s <= cfg_period;
            duty_s   <= cfg_duty;
            dead_s   <= cfg_dead;
            pending  <= 1'b1;
        end else if (pending && (state == S_OFF || wrap)) begin
            period_q <= period_s;
            duty_q   <= duty_s;
            dead_q   <= dead_s;
            pending  <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
            if (!enable) begin
                cnt <= '0;
            end else if (tick_en) begin
                cnt <= (cnt == period_q) ? '0 : cnt + CNT_ONE;
            end
        end
    end

    // Outputs are registered alongside the state so they can never overlap.
    always_ff @(posedge clk_in) begin
        if (rst || !enable) begin
            state  <= S_OFF;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
            dt     <= '0;
        end else begin
            unique case (state)
                S_OFF: begin
                    state  <= raw ? S_HI : S_LO;
                    pwm_hi <= raw;
                    pwm_lo <= ~raw;
                end
                S_HI: begin
                    if (!raw) begin
                        pwm_hi <= 1'b0;
                        if (dead_q == '0) begin
                            state  <= S_LO;
                            pwm_lo <= 1'b1;
                        end else begin
                            state <= S_DTL;
                            dt    <= dead_q;
                        end
                    end
                end
                S_DTL: begin
                    if (raw) begin
                        if (dead_q == '0) begin
                            state  <= S_HI;
                            pwm_hi <= 1'b1;
                        end else begin
                            state <= S_DTH;
                            dt    <= dead_q;
                        end
                    end else if (tick_en) begin
                        if (dt <= DT_ONE) begin
                            state  <= S_LO;
                            pwm_lo <= 1'b1;
                        end else begin
                            dt <= dt - DT_ONE;
                        end
                    end
                end
                S_LO: begin
                    if (raw) begin
                        pwm_lo <= 1'b0;
                        if (dead_q == '0) begin
                            state  <= S_HI;
                            pwm_hi <= 1'b1;
                        end else begin
                            state <= S_DTH;
                            dt    <= dead_q;
                        end
                    end
                end
                S_DTH: begin
                    if (!raw) begin
                        if (dead_q == '0) begin
                            state  <= S_LO;
                            pwm_lo <= 1'b1;
                        end else begin
                            state <= S_DTL;
                            dt    <= dead_q;
                        end
                    end else if (tick_en) begin
                        if (dt <= DT_ONE) begin
                            state  <= S_HI;
                            pwm_hi <= 1'b1;
                        end else begin
                            dt <= dt - DT_ONE;
                        end
                    end
                end
                default: begin
                    state  <= S_OFF;
                    pwm_hi <= 1'b0;
                    pwm_lo <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: start-up, dead band, live config,
// duty/period boundaries, prescaled tick and abort paths.
module tb_pwm_gen;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        tick_en = 1'b0;
    logic        enable = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_period = '0;
    logic [15:0] cfg_duty = '0;
    logic [7:0]  cfg_dead = '0;
    logic        pwm_hi, pwm_lo, period_start;
    logic [15:0] cnt_out;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int tdiv = 1;
    int ovl = 0;
    int w_hi, w_lo, w_ps, w_z, w_zmax, w_ncomp;

    pwm_gen dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .tick_en     (tick_en),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .cfg_dead    (cfg_dead),
        .pwm_hi      (pwm_hi),
        .pwm_lo      (pwm_lo),
        .period_start(period_start),
        .cnt_out     (cnt_out)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in)
        if (pwm_hi === 1'b1 && pwm_lo === 1'b1) ovl++;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
        tick_en = (cyc % tdiv == 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        cfg_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic load_cfg(input int p, input int d, input int dt);
        cfg_period = 16'(p);
        cfg_duty = 16'(d);
        cfg_dead = 8'(dt);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
    endtask

    task automatic window(input int n);
        int run;
        run = 0;
        w_hi = 0; w_lo = 0; w_ps = 0;
        w_z = 0; w_zmax = 0; w_ncomp = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (pwm_hi) w_hi++;
            if (pwm_lo) w_lo++;
            if (period_start) w_ps++;
            if (pwm_hi == pwm_lo) w_ncomp++;
            if (!pwm_hi && !pwm_lo) begin
                w_z++;
                run++;
                if (run > w_zmax) w_zmax = run;
            end else begin
                run = 0;
            end
        end
    endtask

    initial begin
        // reset and basic start
        rst = 1'b1;
        step();
        step();
        chk("rst_hi", int'(pwm_hi), 0);
        chk("rst_lo", int'(pwm_lo), 0);
        chk("rst_ps", int'(period_start), 0);
        chk("rst_cnt", int'(cnt_out), 0);
        chk("rst_rdy", int'(cfg_ready), 1);
        rst = 1'b0;
        cfg_period = 16'd9;
        cfg_duty = 16'd3;
        cfg_dead = 8'd0;
        cfg_valid = 1'b1;
        step();
        chk("off_rdy_fall", int'(cfg_ready), 0);
        cfg_valid = 1'b0;
        step();
        chk("off_rdy_rise", int'(cfg_ready), 1);
        enable = 1'b1;
        step();
        chk("start_hi", int'(pwm_hi), 1);
        chk("start_cnt", int'(cnt_out), 1);
        window(30);
        chk("t1_hi", w_hi, 9);
        chk("t1_lo", w_lo, 21);
        chk("t1_ps", w_ps, 3);
        chk("t1_compl", w_ncomp, 0);

        // dead band
        do_reset();
        load_cfg(9, 5, 2);
        enable = 1'b1;
        repeat (12) step();
        window(30);
        chk("t2_hi", w_hi, 9);
        chk("t2_lo", w_lo, 9);
        chk("t2_z", w_z, 12);
        chk("t2_zrun", w_zmax, 2);
        chk("t2_ps", w_ps, 3);

        // live config update
        do_reset();
        load_cfg(9, 3, 0);
        enable = 1'b1;
        step();
        cfg_duty = 16'd7;
        cfg_valid = 1'b1;
        step();
        chk("t3_rdy_fall", int'(cfg_ready), 0);
        cfg_valid = 1'b0;
        step();
        step();
        chk("t3_keep_d3", int'(pwm_hi), 0);
        repeat (5) step();
        chk("t3_rdy_hold", int'(cfg_ready), 0);
        step();
        chk("t3_rdy_wrap", int'(cfg_ready), 1);
        chk("t3_ps", int'(period_start), 1);
        window(9);
        chk("t3_hi_d7", w_hi, 7);
        cfg_duty = 16'd2;
        cfg_valid = 1'b1;
        step();
        chk("t3w_accept", int'(cfg_ready), 0);
        chk("t3w_ps", int'(period_start), 1);
        cfg_valid = 1'b0;
        window(9);
        chk("t3w_hi_d7", w_hi, 7);
        chk("t3w_rdy_hold", int'(cfg_ready), 0);
        step();
        chk("t3w_rdy_rise", int'(cfg_ready), 1);
        window(10);
        chk("t3w_hi_d2", w_hi, 2);

        // boundaries
        do_reset();
        load_cfg(9, 0, 2);
        enable = 1'b1;
        step();
        window(20);
        chk("d0_lo", w_lo, 20);
        chk("d0_hi", w_hi, 0);
        do_reset();
        load_cfg(9, 10, 3);
        enable = 1'b1;
        step();
        window(20);
        chk("d100_hi", w_hi, 20);
        chk("d100_z", w_z, 0);
        do_reset();
        load_cfg(0, 0, 0);
        enable = 1'b1;
        step();
        window(10);
        chk("p0_ps", w_ps, 10);
        chk("p0_cnt", int'(cnt_out), 0);

        // prescaled tick
        tdiv = 4;
        do_reset();
        load_cfg(3, 2, 0);
        enable = 1'b1;
        repeat (20) step();
        window(48);
        chk("pre_hi", w_hi, 24);
        chk("pre_lo", w_lo, 24);
        chk("pre_ps", w_ps, 3);
        tdiv = 1;

        // abort by enable
        do_reset();
        load_cfg(9, 5, 2);
        enable = 1'b1;
        repeat (3) step();
        chk("ab_mid_hi", int'(pwm_hi), 1);
        enable = 1'b0;
        step();
        chk("ab_hi", int'(pwm_hi), 0);
        chk("ab_lo", int'(pwm_lo), 0);
        chk("ab_cnt", int'(cnt_out), 0);

        // abort by reset in dead band with a pending config
        do_reset();
        load_cfg(9, 5, 2);
        enable = 1'b1;
        repeat (5) step();
        chk("rs_pre_hi", int'(pwm_hi), 1);
        cfg_period = 16'd9;
        cfg_duty = 16'd1;
        cfg_dead = 8'd0;
        cfg_valid = 1'b1;
        step();
        chk("rs_pend", int'(cfg_ready), 0);
        chk("rs_dt_hi", int'(pwm_hi), 0);
        chk("rs_dt_lo", int'(pwm_lo), 0);
        cfg_valid = 1'b0;
        rst = 1'b1;
        enable = 1'b0;
        step();
        chk("rs_hi", int'(pwm_hi), 0);
        chk("rs_lo", int'(pwm_lo), 0);
        chk("rs_cnt", int'(cnt_out), 0);
        chk("rs_rdy", int'(cfg_ready), 1);
        rst = 1'b0;
        repeat (3) step();
        enable = 1'b1;
        step();
        window(10);
        chk("rs_lost_ps", w_ps, 10);
        chk("rs_lost_hi", w_hi, 0);

        chk("no_overlap", ovl, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
